ifetch_prefetch_unit: RTL and testbench

Instruction fetch stage with a small prefetch queue, sitting between the program counter/instruction memory and the decode/control stage. Issues sequential word fetches over a request/response interface, buffers returned instructions with their PC, and presents them to decode with a valid/ready handshake. A redirect (taken branch/jump) flushes buffered and in-flight instructions and restarts fetch at the new target.

---
 rtl/ifetch_pkg.sv | 27 ++
 rtl/ifetch_queue.sv | 73 +++++++
 rtl/ifetch_prefetch_unit.sv | 140 ++++++++++++++
 tb/tb_ifetch_prefetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: types and constants shared by the instruction fetch stage.
//   XLEN            - address / instruction width
//   INSTR_BYTES     - byte stride between sequential instruction words
//   fetch_entry_t   - one buffered instruction together with its PC
//   fetch_state_t   - fetch control state (FAULT is only reachable when the
//                     misaligned-redirect check is built in)
//   align_word()    - clears the byte-offset bits of an address
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: small synchronous FIFO of fetch entries with show-ahead head.
//   clk, reset    - clock, asynchronous active-high reset
//   flush         - empties the queue (takes priority over push/pop)
//   push, entry   - write entry at the tail (ignored when full)
//   pop           - drop the head entry (ignored when empty)
//   head          - entry at the head, valid whenever !empty
//   count         - number of valid entries
//   full, empty   - occupancy flags
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    // Storage is cleared on reset so the head reads as zero out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= entry;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// ifetch_prefetch_unit: sequential instruction fetch with a prefetch queue.
//   Build option: IFETCH_MISALIGN_CHECK_EN - when defined, a redirect to a
//   non-word-aligned target parks the unit in FAULT (fetch_fault=1, no
//   requests) until an aligned redirect arrives. When undefined the low two
//   target bits are ignored and fetch_fault is tied low.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   redirect_valid/redirect_pc  - flush and restart fetch at a new target
//   imem_req_valid/ready/addr   - word fetch request channel
//   imem_rsp_valid/data         - in-order response channel, always accepted
//   dec_valid/ready/instr/pc    - instruction handoff to decode
//   fetch_fault                 - misaligned redirect indication
module ifetch_prefetch_unit
    import ifetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic            fetch_fault
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    // In-flight counters need headroom: after a redirect the stale requests
    // still count as outstanding while a fresh window of DEPTH is issued.
    localparam int FLT_W = CNT_W + 3;

    logic [XLEN-1:0]  fetch_pc_reg;
    logic [XLEN-1:0]  rsp_pc_reg;
    logic [FLT_W-1:0] outstanding_reg;
    logic [FLT_W-1:0] drop_cnt_reg;
    logic [FLT_W-1:0] in_use;
    logic [XLEN-1:0]  target_pc;
    logic             run;
    logic             credit_ok;
    logic             req_fire;
    logic             keep_rsp;
    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    fetch_entry_t     q_head;
    fetch_entry_t     q_entry;

`ifdef IFETCH_MISALIGN_CHECK_EN
    fetch_state_t state_reg;
    fetch_state_t state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= RUN;
        else       state_reg <= state_next;
    end

    // Every redirect re-decides the state, so the last redirect always wins.
    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
        end
    end

    assign run         = (state_reg == RUN);
    assign fetch_fault = (state_reg == FAULT);
    assign target_pc   = redirect_pc;
`else
    assign run         = 1'b1;
    assign fetch_fault = 1'b0;
    assign target_pc   = align_word(redirect_pc);
`endif

    // Entries queued plus live (non-discarded) requests may never exceed the
    // queue size, so every kept response is guaranteed a free slot.
    assign in_use    = FLT_W'(q_count) + outstanding_reg - drop_cnt_reg;
    assign credit_ok = (in_use < FLT_W'(DEPTH));

    assign imem_req_valid = !reset && run && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response arriving in a redirect cycle is stale and is discarded.
    assign keep_rsp = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
    assign q_push   = keep_rsp && !q_full;
    assign q_entry  = '{pc: rsp_pc_reg, instr: imem_rsp_data};

    assign dec_valid = !q_empty && !redirect_valid;
    assign q_pop     = dec_valid && dec_ready;
    assign dec_instr = q_head.instr;
    assign dec_pc    = q_head.pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + FLT_W'(req_fire) - FLT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc_reg <= target_pc;
                rsp_pc_reg   <= target_pc;
                drop_cnt_reg <= outstanding_reg - FLT_W'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc_reg <= fetch_pc_reg + INSTR_BYTES;
                if (q_push)   rsp_pc_reg   <= rsp_pc_reg + INSTR_BYTES;
                if (imem_rsp_valid && (drop_cnt_reg != '0)) begin
                    drop_cnt_reg <= drop_cnt_reg - 1'b1;
                end
            end
        end
    end

    ifetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (q_push),
        .entry (q_entry),
        .pop   (q_pop),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// tb_ifetch_prefetch_unit: directed bench for ifetch_prefetch_unit with a
// configurable-latency in-order instruction memory model.
module tb_ifetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fetch_fault;

    int vectors     = 0;
    int miscompares = 0;
    int lat         = 1;
    int cyc         = 0;
    int nreq;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t pend[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ifetch_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fetch_fault    (fetch_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: a request accepted in cycle M answers in M+lat,
    // strictly in order; it shares reset and forgets pending requests.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && imem_req_valid && imem_req_ready)
                pend.push_back(pend_t'{cyc + lat, imem_req_addr});
            @(posedge clk);
            #1;
            if (reset) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Leaves the bench just inside cycle 1 (first cycle out of reset).
    task automatic apply_reset(input int latency, input logic ready);
        next_cycle();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = ready;
        lat            = latency;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;

        // ---- reset values ----
        sample();
        chk1 ("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_req_addr",  imem_req_addr,  32'h0);
        chk1 ("rst_dec_valid", dec_valid,      1'b0);
        check("rst_dec_instr", dec_instr,      32'h0);
        check("rst_dec_pc",    dec_pc,         32'h0);
        chk1 ("rst_fault",     fetch_fault,    1'b0);

        // ---- streaming, 1-cycle memory, decode always ready ----
        apply_reset(1, 1'b1);
        sample();
        chk1 ("s_c1_req_valid", imem_req_valid, 1'b1);
        check("s_c1_req_addr",  imem_req_addr,  32'h0);
        next_cycle(); sample();
        chk1 ("s_c2_dec_valid", dec_valid,     1'b0);
        check("s_c2_req_addr",  imem_req_addr, 32'h4);
        for (int k = 0; k < 8; k++) begin
            next_cycle(); sample();
            chk1 ("s_dec_valid", dec_valid, 1'b1);
            check("s_dec_pc",    dec_pc,    32'(4 * k));
            if (k == 2) check("s_dec_instr", dec_instr, mem_word(32'h8));
        end

        // ---- decode stalled: queue fills with exactly DEPTH requests ----
        apply_reset(1, 1'b0);
        nreq = 0;
        sample();
        if (imem_req_valid && imem_req_ready) nreq++;
        for (int c = 2; c <= 10; c++) begin
            next_cycle(); sample();
            if (imem_req_valid && imem_req_ready) nreq++;
        end
        check("stall_req_count", 32'(nreq),     32'd4);
        chk1 ("stall_req_valid", imem_req_valid, 1'b0);
        chk1 ("stall_dec_valid", dec_valid,      1'b1);
        check("stall_dec_pc",    dec_pc,         32'h0);
        next_cycle();
        dec_ready = 1'b1;
        sample();
        chk1 ("rel_c11_req_valid", imem_req_valid, 1'b0);
        check("rel_c11_dec_pc",    dec_pc,         32'h0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle(); sample();
            chk1 ("rel_dec_valid", dec_valid, 1'b1);
            check("rel_dec_pc",    dec_pc,    32'(4 * k));
            if (k == 1) begin
                chk1 ("rel_req_valid", imem_req_valid, 1'b1);
                check("rel_req_addr",  imem_req_addr,  32'h10);
            end
        end

        // ---- reset mid-stream with three entries queued ----
        apply_reset(1, 1'b0);
        next_cycle(); next_cycle(); next_cycle(); sample();
        chk1 ("mid_dec_valid_before", dec_valid, 1'b1);
        check("mid_dec_pc_before",    dec_pc,    32'h0);
        next_cycle();
        reset = 1'b1;
        #1;
        chk1("mid_dec_valid_in_reset", dec_valid,      1'b0);
        chk1("mid_req_valid_in_reset", imem_req_valid, 1'b0);
        next_cycle(); next_cycle();
        reset     = 1'b0;
        dec_ready = 1'b1;
        sample();
        chk1 ("mid_restart_req_valid", imem_req_valid, 1'b1);
        check("mid_restart_req_addr",  imem_req_addr,  32'h0);
        next_cycle(); next_cycle(); sample();
        chk1 ("mid_restart_dec_valid", dec_valid, 1'b1);
        check("mid_restart_dec_pc",    dec_pc,    32'h0);
        check("mid_restart_dec_instr", dec_instr, mem_word(32'h0));

        // ---- 3-cycle memory, two requests in flight, redirect ----
        apply_reset(3, 1'b1);
        sample();
        check("lat3_c1_req_addr", imem_req_addr, 32'h0);
        next_cycle();
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sample();
        chk1("lat3_redir_req_valid", imem_req_valid, 1'b0);
        chk1("lat3_redir_dec_valid", dec_valid,      1'b0);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        chk1 ("lat3_c4_req_valid", imem_req_valid, 1'b1);
        check("lat3_c4_req_addr",  imem_req_addr,  32'h100);
        chk1 ("lat3_c4_dec_valid", dec_valid,      1'b0);
        for (int c = 5; c <= 7; c++) begin
            next_cycle(); sample();
            chk1("lat3_stale_dropped", dec_valid, 1'b0);
        end
        next_cycle(); sample();
        chk1 ("lat3_c8_dec_valid", dec_valid, 1'b1);
        check("lat3_c8_dec_pc",    dec_pc,    32'h100);
        check("lat3_c8_dec_instr", dec_instr, mem_word(32'h100));
        next_cycle(); sample();
        check("lat3_c9_dec_pc", dec_pc, 32'h104);

        // ---- redirect coincident with response and decode ready ----
        apply_reset(1, 1'b1);
        next_cycle(); next_cycle(); sample();
        check("rr_c3_dec_pc", dec_pc, 32'h0);
        next_cycle(); sample();
        check("rr_c4_dec_pc", dec_pc, 32'h4);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        sample();
        chk1("rr_redir_dec_valid", dec_valid,      1'b0);
        chk1("rr_redir_req_valid", imem_req_valid, 1'b0);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        chk1 ("rr_c6_dec_valid", dec_valid,     1'b0);
        check("rr_c6_req_addr",  imem_req_addr, 32'h300);
        next_cycle(); sample();
        chk1("rr_c7_dec_valid", dec_valid, 1'b0);
        next_cycle(); sample();
        chk1 ("rr_c8_dec_valid", dec_valid, 1'b1);
        check("rr_c8_dec_pc",    dec_pc,    32'h300);

        // ---- misaligned redirect, then aligned redirect ----
        apply_reset(1, 1'b1);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        sample();
        chk1("mis_redir_req_valid", imem_req_valid, 1'b0);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk1("mis_fault_set",      fetch_fault,    1'b1);
        chk1("mis_fault_no_req",   imem_req_valid, 1'b0);
`else
        chk1 ("mis_fault_tied0",   fetch_fault,    1'b0);
        chk1 ("mis_req_valid",     imem_req_valid, 1'b1);
        check("mis_req_aligned",   imem_req_addr,  32'h100);
`endif
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        sample();
        chk1("mis_redir2_req_valid", imem_req_valid, 1'b0);
        next_cycle();
        redirect_valid = 1'b0;
        sample();
        chk1 ("mis_fault_clear", fetch_fault,    1'b0);
        chk1 ("mis_c5_req_valid", imem_req_valid, 1'b1);
        check("mis_c5_req_addr",  imem_req_addr,  32'h200);
        next_cycle(); sample();
        chk1("mis_c6_dec_valid", dec_valid, 1'b0);
        next_cycle(); sample();
        chk1 ("mis_c7_dec_valid", dec_valid, 1'b1);
        check("mis_c7_dec_pc",    dec_pc,    32'h200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
